xor_diff_checker: RTL and testbench

- Downstream consumer of the 16-bit bitwise XOR stage: its input is the XOR difference word, f = expected ^ received.
- Accumulates mismatch statistics over a frame of difference words: total differing bits, count of nonzero words, index of the first nonzero word.
- Reports one result per frame with a pass/fail flag over a valid/ready handshake.
- Sits between the XOR datapath and the test/status logic.

---
 rtl/xor_diff_checker.sv | 140 ++++++++++++++
 tb/tb_xor_diff_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_diff_checker.sv
// Frame statistics checker for the XOR difference stream: counts differing bits, nonzero words
// and the first error position, then reports once per frame. Optional sticky flag: XDC_STICKY_ERR_EN.
module xor_diff_checker #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] diff_word,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_bits,
    output logic [CNT_W-1:0] err_words,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             frame_pass,
    output logic             err_sticky
);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic [PC_W-1:0]  pop;
    logic             nonzero;
    logic             beat;
    logic             first_beat;
    logic [CNT_W-1:0] base_bits;
    logic [CNT_W-1:0] base_words;
    logic [CNT_W-1:0] cur_idx;
    logic [SUM_W-1:0] bits_sum;
    logic [SUM_W-1:0] words_sum;
    logic [CNT_W-1:0] bits_next;
    logic [CNT_W-1:0] words_next;
    logic [CNT_W-1:0] first_next;
    logic [CNT_W-1:0] idx_next;

    assign beat       = in_valid && in_ready;
    assign nonzero    = (diff_word != '0);
    assign first_beat = (state == IDLE);

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PC_W'(diff_word[i]);
        end
    end

    // A beat in IDLE starts a fresh frame, so the accumulators are seeded from zero
    // instead of from the previous frame's held result.
    always_comb begin
        base_bits  = first_beat ? '0 : err_bits;
        base_words = first_beat ? '0 : err_words;
        cur_idx    = first_beat ? '0 : idx;

        bits_sum   = SUM_W'(base_bits) + SUM_W'(pop);
        bits_next  = (bits_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bits_sum[CNT_W-1:0];

        words_sum  = SUM_W'(base_words) + SUM_W'(nonzero);
        words_next = (words_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : words_sum[CNT_W-1:0];

        // err_words==0 means no earlier error; first_err_idx alone is ambiguous once the index saturates
        if (nonzero && (first_beat || (err_words == '0))) begin
            first_next = cur_idx;
        end else if (first_beat) begin
            first_next = CNT_MAX;
        end else begin
            first_next = first_err_idx;
        end

        idx_next = (cur_idx == CNT_MAX) ? CNT_MAX : cur_idx + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            err_bits      <= '0;
            err_words     <= '0;
            first_err_idx <= CNT_MAX;
            frame_pass    <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        err_bits      <= bits_next;
                        err_words     <= words_next;
                        first_err_idx <= first_next;
                        idx           <= idx_next;
                        if (in_last) begin
                            state      <= REPORT;
                            in_ready   <= 1'b0;
                            out_valid  <= 1'b1;
                            frame_pass <= (bits_next == '0);
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef XDC_STICKY_ERR_EN
    logic sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= 1'b0;
        end else if (beat && in_last && (bits_next != '0)) begin
            sticky <= 1'b1;
        end
    end

    assign err_sticky = sticky;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_xor_diff_checker.sv
// Self-checking bench for xor_diff_checker: a full-width instance and a CNT_W=4 instance share
// the same stimulus and are compared against a frame-level reference model.
module tb_xor_diff_checker;

    logic        clk;
    logic        rst;
    logic [15:0] diff_word;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] err_bits;
    logic [15:0] err_words;
    logic [15:0] first_err_idx;
    logic        frame_pass;
    logic        err_sticky;

    logic        in_ready4;
    logic        out_valid4;
    logic [3:0]  err_bits4;
    logic [3:0]  err_words4;
    logic [3:0]  first_err_idx4;
    logic        frame_pass4;
    logic        err_sticky4;

    int vectors;
    int miscompares;
    bit sticky_model;

    xor_diff_checker #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .diff_word(diff_word), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .err_bits(err_bits), .err_words(err_words), .first_err_idx(first_err_idx),
        .frame_pass(frame_pass), .err_sticky(err_sticky)
    );

    xor_diff_checker #(.WIDTH(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .diff_word(diff_word), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready4), .out_valid(out_valid4), .out_ready(out_ready),
        .err_bits(err_bits4), .err_words(err_words4), .first_err_idx(first_err_idx4),
        .frame_pass(frame_pass4), .err_sticky(err_sticky4)
    );

    always #5 clk = ~clk;

    function automatic int satMax(input int cw);
        return (1 << cw) - 1;
    endfunction

    function automatic int clampTo(input int v, input int cw);
        return (v > satMax(cw)) ? satMax(cw) : v;
    endfunction

    function automatic int firstNonzero(input logic [15:0] words[$]);
        foreach (words[i]) begin
            if (words[i] != 16'h0000) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_err_bits", 32'(err_bits), 0);
        checkOutput("rst_err_words", 32'(err_words), 0);
        checkOutput("rst_first_idx", 32'(first_err_idx), 32'hFFFF);
        checkOutput("rst_frame_pass", 32'(frame_pass), 0);
        checkOutput("rst_sticky", 32'(err_sticky), 0);
        checkOutput("rst_in_ready4", 32'(in_ready4), 1);
        checkOutput("rst_out_valid4", 32'(out_valid4), 0);
        checkOutput("rst_first_idx4", 32'(first_err_idx4), 32'hF);
        checkOutput("rst_sticky4", 32'(err_sticky4), 0);
    endtask

    // Sends one frame (with optional idle gaps), checks the result for both instances,
    // optionally stalls out_ready, then releases the result.
    task automatic applyStimulus(input logic [15:0] words[$], input int bubble_pct, input int hold);
        int raw_bits;
        int raw_words;
        int first;
        int eb16, ew16, ef16, eb4, ew4, ef4;
        bit epass;

        raw_bits  = 0;
        raw_words = 0;
        foreach (words[i]) begin
            raw_bits += $countones(words[i]);
            if (words[i] != 16'h0000) raw_words++;
        end
        first = firstNonzero(words);
        eb16  = clampTo(raw_bits, 16);
        ew16  = clampTo(raw_words, 16);
        ef16  = (first < 0) ? satMax(16) : clampTo(first, 16);
        eb4   = clampTo(raw_bits, 4);
        ew4   = clampTo(raw_words, 4);
        ef4   = (first < 0) ? satMax(4) : clampTo(first, 4);
        epass = (raw_bits == 0);
`ifdef XDC_STICKY_ERR_EN
        if (!epass) sticky_model = 1'b1;
`endif

        out_ready = 1'b0;
        foreach (words[i]) begin
            while ($urandom_range(0, 99) < bubble_pct) begin
                in_valid  = 1'b0;
                in_last   = 1'($urandom_range(0, 1));
                diff_word = 16'($urandom);
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b1;
            diff_word = words[i];
            in_last   = (i == words.size() - 1);
            if (in_last && hold == 0) out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        checkOutput("out_valid", 32'(out_valid), 1);
        checkOutput("in_ready_report", 32'(in_ready), 0);
        checkOutput("err_bits", 32'(err_bits), 32'(eb16));
        checkOutput("err_words", 32'(err_words), 32'(ew16));
        checkOutput("first_err_idx", 32'(first_err_idx), 32'(ef16));
        checkOutput("frame_pass", 32'(frame_pass), 32'(epass));
        checkOutput("err_sticky", 32'(err_sticky), 32'(sticky_model));
        checkOutput("out_valid4", 32'(out_valid4), 1);
        checkOutput("err_bits4", 32'(err_bits4), 32'(eb4));
        checkOutput("err_words4", 32'(err_words4), 32'(ew4));
        checkOutput("first_err_idx4", 32'(first_err_idx4), 32'(ef4));
        checkOutput("frame_pass4", 32'(frame_pass4), 32'(epass));
        checkOutput("err_sticky4", 32'(err_sticky4), 32'(sticky_model));

        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", 32'(out_valid), 1);
            checkOutput("hold_in_ready", 32'(in_ready), 0);
            checkOutput("hold_err_bits", 32'(err_bits), 32'(eb16));
            checkOutput("hold_first_idx", 32'(first_err_idx), 32'(ef16));
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("release_out_valid", 32'(out_valid), 0);
        checkOutput("release_in_ready", 32'(in_ready), 1);
        checkOutput("release_out_valid4", 32'(out_valid4), 0);
        checkOutput("idle_err_words", 32'(err_words), 32'(ew16));
        checkOutput("idle_sticky", 32'(err_sticky), 32'(sticky_model));
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        sticky_model = 1'b0;
        #1;
        checkReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] q[$];
        int len;
        int r;

        vectors      = 0;
        miscompares  = 0;
        sticky_model = 1'b0;
        clk          = 1'b0;
        rst          = 1'b1;
        diff_word    = '0;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        out_ready    = 1'b0;

        #12;
        checkReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed frames");
        q = {16'hAA55, 16'h3C3C};
        applyStimulus(q, 0, 0);
        q = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
        applyStimulus(q, 0, 0);
        q = {16'h0000, 16'h0000, 16'h8001};
        applyStimulus(q, 0, 5);
        q = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        applyStimulus(q, 0, 1);
        q = {16'h0000};
        applyStimulus(q, 0, 0);

        $display("[TB] reset in the middle of a frame");
        in_valid  = 1'b1;
        in_last   = 1'b0;
        diff_word = 16'h00F0;
        @(posedge clk);
        #1;
        diff_word = 16'h0F00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pulseReset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("aborted_out_valid", 32'(out_valid), 0);
        end
        q = {16'h0001};
        applyStimulus(q, 0, 0);

        $display("[TB] pass after fail, then reset");
        q = {16'h0000, 16'h0000};
        applyStimulus(q, 0, 0);
        pulseReset();

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(1, 20));
            q.delete();
            for (int i = 0; i < len; i++) begin
                r = int'($urandom_range(0, 3));
                if (r == 0)      q.push_back(16'($urandom));
                else if (r == 1) q.push_back(16'(1 << $urandom_range(0, 15)));
                else             q.push_back(16'h0000);
            end
            applyStimulus(q, 30, int'($urandom_range(0, 3)));
        end

        pulseReset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
